serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor. It processes one bit per clock through a single full-adder slice and a registered carry. It trades latency for area against the combinational gate-level full adder and extends it with operand width, subtract mode, overflow detection and a start/done handshake. It sits in the arithmetic datapath wherever a WIDTH-bit add/sub is needed infrequently and area matters more than throughput.

---
 rtl/serial_arith_pkg.sv | 26 ++
 rtl/full_adder_bit.sv | 19 +
 rtl/serial_addsub.sv | 157 +++++++++++++++
 tb/tb_serial_addsub.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared definitions for the bit-serial arithmetic blocks:
//               FSM state encoding and the legal operand-width range.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

  // State encoding shared by every serial arithmetic engine
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Supported operand widths
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : Single-bit combinational full-adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = x_i ^ y_i ^ cin_i;
  assign cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial WIDTH-bit adder/subtractor. One bit per clock
//               through a single full-adder slice with a registered carry,
//               start/done handshake, carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Reject unsupported widths at elaboration time
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_addsub: WIDTH out of supported range");
  end

  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_PENULT = CNT_W'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;     // carry into the MSB slice
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  // The one adder slice, fed by the LSBs of the operand shift registers
  full_adder_bit u_fa (
    .x_i    (opa_q[0]),
    .y_i    (opb_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_c)
  );

  // Next-state logic: accept in IDLE/DONE, one bit per cycle in RUN
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;   // done is a single-cycle pulse

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          cmsb_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == C_CNT_PENULT) begin
          cmsb_d = fa_c;
        end
        if (cnt_q == C_CNT_LAST) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = fa_c ^ cmsb_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub: directed vector table,
//               randomized operations against an arithmetic reference model,
//               and hand-written handshake/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  localparam int WIDTH = 8;
  localparam int TIMEOUT = 3 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vsub;
    logic [WIDTH-1:0] e_sum;
    logic             e_cout;
    logic             e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values
  task automatic ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                           output logic [WIDTH-1:0] r_sum, output logic r_cout, output logic r_ovf);
    longint ux, uy, sx, sy, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= (64'sd1 <<< (WIDTH - 1))) ? ux - (64'sd1 <<< WIDTH) : ux;
    sy = (uy >= (64'sd1 <<< (WIDTH - 1))) ? uy - (64'sd1 <<< WIDTH) : uy;
    if (s) begin
      r_sum  = WIDTH'(ux - uy);
      r_cout = (ux >= uy);          // 1 = no borrow
      sr     = sx - sy;
    end else begin
      r_sum  = WIDTH'(ux + uy);
      r_cout = ((ux + uy) >= (64'sd1 <<< WIDTH));
      sr     = sx + sy;
    end
    r_ovf = (sr > (64'sd1 <<< (WIDTH - 1)) - 1) || (sr < -(64'sd1 <<< (WIDTH - 1)));
  endtask

  // Launch one operation, wait (bounded) for done, check latency and result
  task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input logic [WIDTH-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    int lat;
    a = x; b = y; sub = s; start = 1'b1;
    tick;
    start = 1'b0;
    check({name, " busy after accept"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      tick;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(WIDTH));
    check({name, " sum"}, 64'(sum), 64'(e_sum));
    check({name, " cout"}, 64'(cout), 64'(e_cout));
    check({name, " ovf"}, 64'(ovf), 64'(e_ovf));
    check({name, " busy at done"}, 64'(busy), 64'd0);
    tick;
    check({name, " done pulse width"}, 64'(done), 64'd0);
    check({name, " sum held"}, 64'(sum), 64'(e_sum));
  endtask

  initial begin
    logic [WIDTH-1:0] rx, ry, es;
    logic             rs, ec, eo;
    int               pulses, cyc, first_done, second_done;
    logic [WIDTH-1:0] cap_sum;
    logic             cap_cout, cap_ovf, held_ok;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

    // Reset state
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
             vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      rs = 1'($urandom_range(1, 0));
      ref_model(rx, ry, rs, es, ec, eo);
      run_op($sformatf("rand%0d", i), rx, ry, rs, es, ec, eo);
    end

    // start and new operands pulsed while busy are ignored
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    pulses = 0; cap_sum = '0; cap_cout = 1'b1; cap_ovf = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3 || c == 5) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick;
      if (done) begin
        pulses++;
        cap_sum = sum; cap_cout = cout; cap_ovf = ovf;
      end
    end
    start = 1'b0;
    check("busy-start done count", 64'(pulses), 64'd1);
    check("busy-start sum", 64'(cap_sum), 64'h10);
    check("busy-start cout", 64'(cap_cout), 64'd0);
    check("busy-start ovf", 64'(cap_ovf), 64'd0);

    // start held high through DONE: back-to-back operations. The DONE cycle
    // is the accept cycle, so the second done follows WIDTH+1 cycles later.
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    tick;
    a = 8'h01; b = 8'h02;
    first_done = -1; second_done = -1; held_ok = 1'b1;
    for (cyc = 1; cyc <= 3 * TIMEOUT; cyc++) begin
      tick;
      if (done && first_done < 0) begin
        first_done = cyc;
      end else if (done && second_done < 0) begin
        second_done = cyc;
        start = 1'b0;
        break;
      end else if (first_done >= 0 && sum !== 8'h10) begin
        held_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b first done latency", 64'(first_done), 64'(WIDTH));
    check("b2b done spacing", 64'(second_done - first_done), 64'(WIDTH + 1));
    check("b2b first sum held", 64'(held_ok), 64'd1);
    check("b2b second sum", 64'(sum), 64'h03);
    tick;
    check("b2b no third done", 64'(done), 64'd0);

    // Asynchronous reset in the middle of RUN
    a = 8'hF0; b = 8'h0F; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst sum", 64'(sum), 64'd0);
    check("midrst cout", 64'(cout), 64'd0);
    check("midrst ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2 * WIDTH; c++) begin
      tick;
      if (done || busy) pulses++;
    end
    check("midrst no activity after release", 64'(pulses), 64'd0);
    run_op("post-reset", 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
